grayscale: RTL and testbench
============================

# grayscale

Pipelined RGB-to-grayscale converter with selectable rounding. It computes a weighted luminance from a 24-bit RGB pixel, rounds it to 8 bits in one of three modes, and registers the result. It sits at the front of the halftone path, feeding 8-bit gray samples to the halftoning/dither stage.

## Interface
Parameters: none; the weights are fixed constants held in the package.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- mode  input  2  rounding select: 0 = round-half-up, 1 = round-down (truncate), 2 = round-half-to-even, 3 = round-down
- color  input  24  pixel: [23:16] = R, [15:8] = G, [7:0] = B, all unsigned
- gray  output  8  registered rounded luminance

## Operation
- Weighted sum: S = 77·R + 150·G + 29·B, unsigned, 16 bits. The weights sum to 256, so the maximum is 65280 and no overflow occurs.
- Split S into I = S[15:8] (integer part) and F = S[7:0] (fraction in 1/256 steps).
- Mode 0, round-half-up: gray = I + (F ≥ 128).
- Mode 1, round-down: gray = I.
- Mode 2, round-half-to-even:
  - F > 128: gray = I + 1.
  - F < 128: gray = I.
  - F = 128: gray = I + I[0], so the result is always even.
- Mode 3: identical to mode 1; it is a reserved encoding.
- No saturation is needed. When S ≤ 65280, I + 1 can only occur with I ≤ 254, so gray never exceeds 255.
- The datapath is purely combinational up to the output register. There is no handshake, and a new pixel is accepted every cycle.

## Timing
- gray is registered. At rising edge n it captures the rounded result of the color and mode values present at edge n.
- Latency is 1 cycle and throughput is 1 pixel per cycle.
- Changing mode alone with color held changes gray at the next edge.
- While rst = 1, gray = 8'h00, asynchronously and immediately.
- On rst deassertion, gray is first updated at the next rising edge with clk.
- A reset asserted mid-stream discards the pending result. No stale value appears after release.
- Inputs must be stable for setup/hold around the rising edge. There are no internal state or multicycle paths.

## Structure
- Package grayscale_pkg holds:
  - the weight constants W_R = 77, W_G = 150, W_B = 29;
  - the mode encodings MODE_HALF_UP, MODE_DOWN, MODE_EVEN, MODE_RSVD;
  - the half constant HALF = 8'd128.
- Sub-module grayscale_round: takes S[15:0] and mode and produces the 8-bit rounded value, combinationally.
- The top level holds the weighted-sum multipliers/adder, the grayscale_round instance and the output register.

## Test plan
- Reset: hold rst = 1 with color = 24'hFFFFFF.
  - gray = 0 immediately.
  - After release, the next edge gives gray = 255.
- Extremes, all modes:
  - 24'h000000 → 0.
  - 24'hFFFFFF → 255.
  - 24'h808080 → 128.
- Odd tie: color = 24'h6F0001 gives S = 8576 (33.5). Mode 0 → 34, mode 1 → 33, mode 2 → 34, mode 3 → 33.
- Even tie: color = 24'h920100 gives S = 11392 (44.5). Mode 0 → 45, mode 1 → 44, mode 2 → 44.
- Non-tie and latency: color = 24'h010000 gives S = 77. All modes → 0.
  - Then switch to 24'h00FF00: S = 38250, I = 149, F = 106.
  - All modes give 149, appearing exactly one edge after the change.
- Back-to-back pixels with rst pulsed mid-stream:
  - gray drops to 0 during the pulse.
  - The result stream resumes with 1-cycle latency and no stale value.

Source files
------------

// File: rtl/grayscale_pkg.sv
// Shared constants for the RGB-to-grayscale front end of the halftone path.
// Luminance weights sum to 256 so the weighted sum is a 8.8 fixed-point gray level.
package grayscale_pkg;

  localparam logic [7:0] W_R  = 8'd77;
  localparam logic [7:0] W_G  = 8'd150;
  localparam logic [7:0] W_B  = 8'd29;
  localparam logic [7:0] HALF = 8'd128;

  typedef enum logic [1:0] {
    MODE_HALF_UP = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_EVEN    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

endpackage

// File: rtl/grayscale_if.sv
// Pixel-in / gray-out bundle; there is no handshake, one pixel per cycle.
interface grayscale_if;
  logic [1:0]  mode;
  logic [23:0] color;
  logic [7:0]  gray;

  modport master (output mode, output color, input gray);
  modport slave  (input mode, input color, output gray);
endinterface

// File: rtl/grayscale_round.sv
// Rounds an 8.8 fixed-point luminance to 8 bits in the selected mode.
// Purely combinational; the caller registers the result.
module grayscale_round
  import grayscale_pkg::*;
(
  input  logic [15:0] i_sum,
  input  logic [1:0]  i_mode,
  output logic [7:0]  o_gray
);

  logic [7:0] w_int;
  logic [7:0] w_frac;
  logic [7:0] w_inc;

  assign w_int  = i_sum[15:8];
  assign w_frac = i_sum[7:0];
  // Cannot wrap: a nonzero fraction implies the integer part is at most 254.
  assign w_inc  = w_int + 8'd1;

  always_comb begin
    o_gray = w_int;
    case (mode_e'(i_mode))
      MODE_HALF_UP: begin
        if (w_frac >= HALF) o_gray = w_inc;
      end
      MODE_EVEN: begin
        if ((w_frac > HALF) || ((w_frac == HALF) && w_int[0])) o_gray = w_inc;
      end
      default: begin
        o_gray = w_int;
      end
    endcase
  end

endmodule

// File: rtl/grayscale.sv
// RGB-to-grayscale converter: weighted sum, selectable rounding, one output register.
// Latency one cycle, throughput one pixel per cycle.
module grayscale
  import grayscale_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  grayscale_if.slave px
);

  logic [15:0] w_prodR;
  logic [15:0] w_prodG;
  logic [15:0] w_prodB;
  logic [15:0] w_sum;
  logic [7:0]  w_rounded;
  logic [7:0]  r_gray;

  assign w_prodR = 16'(W_R) * 16'(px.color[23:16]);
  assign w_prodG = 16'(W_G) * 16'(px.color[15:8]);
  assign w_prodB = 16'(W_B) * 16'(px.color[7:0]);
  // Maximum is 255*256 = 65280, so the 16-bit sum never overflows.
  assign w_sum   = w_prodR + w_prodG + w_prodB;

  grayscale_round u_round (
    .i_sum  (w_sum),
    .i_mode (px.mode),
    .o_gray (w_rounded)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_gray <= 8'h00;
    else     r_gray <= w_rounded;
  end

  assign px.gray = r_gray;

endmodule

// File: tb/tb_grayscale.sv
// Self-checking bench for grayscale: directed vectors with literal expectations
// plus an arithmetic reference model compared against the output every cycle.
module tb_grayscale;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  logic [7:0] modelGray;

  grayscale_if px ();

  grayscale dut (
    .clk (clk),
    .rst (rst),
    .px  (px.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: luminance as an integer in 1/256 units, rounded with plain integer math.
  function automatic logic [7:0] refGray(input logic [23:0] c, input logic [1:0] m);
    int s, q, r, g;
    s = 77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0]);
    q = s / 256;
    r = s % 256;
    case (m)
      2'd0:    g = (r >= 128) ? q + 1 : q;
      2'd2:    g = (r > 128) ? q + 1 : ((r < 128) ? q : q + (q % 2));
      default: g = q;
    endcase
    return 8'(g);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) modelGray <= 8'h00;
    else     modelGray <= refGray(px.color, px.mode);
  end

  always @(negedge clk) begin
    nChecks++;
    if (px.gray !== modelGray) begin
      nFails++;
      $display("[TB] FAIL model-compare t=%0t: got %0d, expected %0d (color=%h mode=%0d)",
               $time, px.gray, modelGray, px.color, px.mode);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] expected);
    nChecks++;
    if (px.gray !== expected) begin
      nFails++;
      $display("[TB] FAIL %s t=%0t: got %0d, expected %0d", name, $time, px.gray, expected);
    end
  endtask

  // Drive new inputs shortly after a rising edge so they are captured at the next one.
  task automatic applyStimulus(input logic [23:0] c, input logic [1:0] m);
    @(posedge clk);
    #2;
    px.color = c;
    px.mode  = m;
  endtask

  task automatic applyAndCheck(input string name, input logic [23:0] c,
                               input logic [1:0] m, input logic [7:0] expected);
    applyStimulus(c, m);
    @(posedge clk);
    #1;
    checkOutput(name, expected);
  endtask

  logic [23:0] tieColor [5];
  logic [7:0]  tieExp   [5][4];

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst      = 1'b1;
    px.color = 24'hFFFFFF;
    px.mode  = 2'd0;

    #1;
    checkOutput("reset-immediate", 8'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset-held", 8'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset-release-no-update", 8'd0);
    @(posedge clk);
    #1;
    checkOutput("reset-first-edge", 8'd255);

    tieColor[0] = 24'h000000; tieExp[0] = '{8'd0, 8'd0, 8'd0, 8'd0};
    tieColor[1] = 24'hFFFFFF; tieExp[1] = '{8'd255, 8'd255, 8'd255, 8'd255};
    tieColor[2] = 24'h808080; tieExp[2] = '{8'd128, 8'd128, 8'd128, 8'd128};
    tieColor[3] = 24'h6F0001; tieExp[3] = '{8'd34, 8'd33, 8'd34, 8'd33};
    tieColor[4] = 24'h920100; tieExp[4] = '{8'd45, 8'd44, 8'd44, 8'd44};
    for (int v = 0; v < 5; v++) begin
      for (int m = 0; m < 4; m++) begin
        applyAndCheck($sformatf("vec%0d-mode%0d", v, m), tieColor[v], 2'(m), tieExp[v][m]);
      end
    end

    // Mode change alone with colour held takes effect at the next edge.
    applyAndCheck("mode-switch-down", 24'h6F0001, 2'd1, 8'd33);
    applyAndCheck("mode-switch-up",   24'h6F0001, 2'd0, 8'd34);

    for (int m = 0; m < 4; m++) begin
      applyAndCheck($sformatf("small-mode%0d", m), 24'h010000, 2'(m), 8'd0);
      applyStimulus(24'h00FF00, 2'(m));
      #1;
      checkOutput($sformatf("latency-before-mode%0d", m), 8'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("latency-after-mode%0d", m), 8'd149);
      applyStimulus(24'h010000, 2'(m));
    end

    // Back-to-back stream with a reset pulse in the middle.
    applyStimulus(24'h808080, 2'd0);
    applyStimulus(24'hFFFFFF, 2'd0);
    @(posedge clk);
    #1;
    checkOutput("stream-pre-reset", 8'd255);
    px.color = 24'h6F0001;
    px.mode  = 2'd2;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("stream-reset-drop", 8'd0);
    @(posedge clk);
    #1;
    checkOutput("stream-reset-hold", 8'd0);
    rst = 1'b0;
    #2;
    checkOutput("stream-no-stale", 8'd0);
    @(posedge clk);
    #1;
    checkOutput("stream-resume", 8'd34);
    applyAndCheck("stream-next", 24'h920100, 2'd2, 8'd44);
    applyAndCheck("stream-last", 24'h00FF00, 2'd3, 8'd149);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
